// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer
package seq_pkg;
   typedef enum logic [3:0] {
      IDLE, ENTRY, READY, EXEC, WAIT1, OVFCHK, WAIT2, STORE, DONE
   } state_t;
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int GAP_W   = 4;
   // nibble 0 is the opcode, so slots fill from the MSB downwards
   function automatic int slot_msb(input int instr_w, input int nib_w, input logic [1:0] idx);
      return instr_w - 1 - nib_w * int'(idx);
   endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge detector for a debounced button level
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);
   logic btn_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) btn_q <= 1'b0;
      else      btn_q <= btn;
   assign rise = btn & ~btn_q;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: assembles an instruction from switch nibbles and issues
// the timed execute / overflow-check / store strobes for the datapath
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int GAP_CYCLES = 4,
   parameter int NIB_W      = 4,
   parameter int INSTR_W    = 4 * NIB_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NIB_W-1:0]   sw,
   input  logic               load_btn,
   input  logic               run_btn,
   input  logic               clr_btn,
   input  logic               overflow,
   output logic [INSTR_W-1:0] instruction,
   output logic               execute_st,
   output logic               overflow_st,
   output logic               reg_store,
   output logic [1:0]         nib_idx,
   output logic               busy,
   output logic               done,
   output logic               ovf_flag
);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
   logic load_e, run_e, clr_e;
   state_t state, state_nx;
   logic [GAP_W-1:0] cnt, cnt_nx;
   logic [INSTR_W-1:0] instr_nx;
   logic [1:0] idx_nx;
   logic ovf_nx;

   btn_edge u_load (.clk(clk), .rst(rst), .btn(load_btn), .rise(load_e));
   btn_edge u_run  (.clk(clk), .rst(rst), .btn(run_btn),  .rise(run_e));
   btn_edge u_clr  (.clk(clk), .rst(rst), .btn(clr_btn),  .rise(clr_e));

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      instr_nx = instruction;
      idx_nx   = nib_idx;
      ovf_nx   = ovf_flag;
      if (clr_e) begin
         state_nx = IDLE;
         instr_nx = '0;
         idx_nx   = '0;
         ovf_nx   = 1'b0;
      end else begin
         case (state)
            IDLE, ENTRY: if (load_e) begin
               instr_nx[slot_msb(INSTR_W, NIB_W, nib_idx) -: NIB_W] = sw;
               idx_nx   = nib_idx + 2'd1;
               state_nx = (nib_idx == 2'd3) ? READY : ENTRY;
            end
            READY, DONE: if (run_e) begin
               state_nx = EXEC;
               ovf_nx   = 1'b0;
            end else if (load_e) begin
               instr_nx[INSTR_W-1 -: NIB_W] = sw;
               idx_nx   = 2'd1;
               state_nx = ENTRY;
               ovf_nx   = 1'b0;
            end
            EXEC: begin
               state_nx = WAIT1;
               cnt_nx   = GAP_LOAD;
            end
            WAIT1: if (cnt == '0) state_nx = OVFCHK;
                   else           cnt_nx = cnt - 1'b1;
            OVFCHK: begin
               state_nx = WAIT2;
               cnt_nx   = GAP_LOAD;
            end
            // overflow is only trusted once the ALU has settled for the full gap
            WAIT2: if (cnt == '0) begin
               state_nx = overflow ? DONE : STORE;
               ovf_nx   = overflow;
            end else cnt_nx = cnt - 1'b1;
            STORE:   state_nx = DONE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         instruction <= '0;
         nib_idx     <= '0;
         ovf_flag    <= 1'b0;
         execute_st  <= 1'b0;
         overflow_st <= 1'b0;
         reg_store   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         instruction <= instr_nx;
         nib_idx     <= idx_nx;
         ovf_flag    <= ovf_nx;
         execute_st  <= state_nx == EXEC;
         overflow_st <= state_nx == OVFCHK;
         reg_store   <= state_nx == STORE;
         busy        <= state_nx inside {EXEC, WAIT1, OVFCHK, WAIT2, STORE};
         done        <= state_nx == DONE;
      end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized bench against a nibble/timeline reference model
module tb_instr_sequencer;
   localparam int G = 4;
   localparam int S = 2 * G + 2;

   logic clk = 1'b0, rst = 1'b0;
   logic [3:0] sw = '0;
   logic load_btn = 1'b0, run_btn = 1'b0, clr_btn = 1'b0, overflow = 1'b0;
   logic [15:0] instruction;
   logic execute_st, overflow_st, reg_store, busy, done, ovf_flag;
   logic [1:0] nib_idx;

   int n_cmp = 0, n_err = 0;

   logic [3:0] m_nib [4];
   int m_idx;
   bit m_ready, m_done, m_ovf;

   instr_sequencer #(.GAP_CYCLES(G), .NIB_W(4), .INSTR_W(16)) dut (
      .clk(clk), .rst(rst), .sw(sw), .load_btn(load_btn), .run_btn(run_btn),
      .clr_btn(clr_btn), .overflow(overflow), .instruction(instruction),
      .execute_st(execute_st), .overflow_st(overflow_st), .reg_store(reg_store),
      .nib_idx(nib_idx), .busy(busy), .done(done), .ovf_flag(ovf_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] m_word();
      return {m_nib[0], m_nib[1], m_nib[2], m_nib[3]};
   endfunction

   task automatic m_clear();
      foreach (m_nib[i]) m_nib[i] = 4'h0;
      m_idx = 0; m_ready = 0; m_done = 0; m_ovf = 0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".instr"}, 32'(instruction), 32'(m_word()));
      check({tag, ".idx"}, 32'(nib_idx), 32'(m_idx));
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".exe"}, 32'(execute_st), 32'd0);
      check({tag, ".ovs"}, 32'(overflow_st), 32'd0);
      check({tag, ".st"}, 32'(reg_store), 32'd0);
      check({tag, ".done"}, 32'(done), 32'(m_done));
      check({tag, ".ovf"}, 32'(ovf_flag), 32'(m_ovf));
   endtask

   task automatic load_nib(input logic [3:0] v);
      sw = v;
      load_btn = 1'b1;
      step();
      load_btn = 1'b0;
      if (m_ready) begin
         m_nib[0] = v; m_idx = 1; m_ready = 0; m_done = 0; m_ovf = 0;
      end else begin
         m_nib[m_idx] = v;
         m_idx = (m_idx + 1) % 4;
         m_ready = (m_idx == 0);
      end
      check_idle("load");
      step();
   endtask

   // run edge in cycle 0; ovmode 0: overflow low, 1: high from cycle 7, 2: random
   task automatic do_run(input bit noise, input int clr_at, input int ovmode);
      bit ov = 0, cleared = 0;
      run_btn = 1'b1;
      load_btn = noise;
      step();
      for (int c = 1; c <= S + 4; c++) begin
         if (cleared) begin
            check("clr.instr", 32'(instruction), 32'd0);
            check("clr.idx", 32'(nib_idx), 32'd0);
            check("clr.busy", 32'(busy), 32'd0);
            check("clr.exe", 32'(execute_st), 32'd0);
            check("clr.ovs", 32'(overflow_st), 32'd0);
            check("clr.st", 32'(reg_store), 32'd0);
            check("clr.done", 32'(done), 32'd0);
            check("clr.ovf", 32'(ovf_flag), 32'd0);
         end else begin
            check("run.instr", 32'(instruction), 32'(m_word()));
            check("run.idx", 32'(nib_idx), 32'd0);
            check("run.exe", 32'(execute_st), 32'(c == 1));
            check("run.ovs", 32'(overflow_st), 32'(c == G + 2));
            check("run.st", 32'(reg_store), 32'(!ov && c == S + 1));
            check("run.busy", 32'(busy), 32'(c <= S || (c == S + 1 && !ov)));
            check("run.done", 32'(done), 32'(c > S && (ov || c >= S + 2)));
            check("run.ovf", 32'(ovf_flag), 32'(c > S && ov));
         end
         run_btn = 1'b0;
         load_btn = 1'b0;
         clr_btn = 1'b0;
         sw = 4'($urandom);
         if (noise && c >= 2 && c <= 9) begin
            load_btn = 1'($urandom);
            run_btn = 1'($urandom);
         end
         overflow = (ovmode == 2) ? 1'($urandom) : (ovmode == 1 && c >= 7);
         if (c == S) ov = overflow;
         if (c == clr_at) clr_btn = 1'b1;
         step();
         if (c == clr_at) cleared = 1;
      end
      clr_btn = 1'b0;
      overflow = 1'b0;
      if (cleared) m_clear();
      else begin
         m_ready = 1; m_done = 1; m_ovf = ov;
      end
   endtask

   initial begin
      m_clear();
      repeat (2) step();
      check_idle("reset");
      rst = 1'b1;
      step();
      check_idle("post_reset");

      load_nib(4'h1); load_nib(4'h2); load_nib(4'h3); load_nib(4'h4);
      check("plan.instr", 32'(instruction), 32'h1234);
      do_run(0, 0, 0);
      do_run(0, 0, 1);
      do_run(1, 0, 0);
      check("plan.held", 32'(instruction), 32'h1234);
      do_run(0, 3, 0);

      // run ignored in IDLE and mid-entry
      for (int k = 0; k < 2; k++) begin
         if (k == 1) begin load_nib(4'hA); load_nib(4'hB); end
         run_btn = 1'b1;
         step();
         run_btn = 1'b0;
         repeat (3) begin
            check_idle("ignored_run");
            step();
         end
      end
      while (!m_ready) load_nib(4'($urandom));

      // asynchronous reset in cycle 5 of an execution
      run_btn = 1'b1;
      step();
      run_btn = 1'b0;
      repeat (4) step();
      rst = 1'b0;
      #1;
      m_clear();
      check_idle("async_rst");
      repeat (3) step();
      rst = 1'b1;
      step();
      run_btn = 1'b1;
      step();
      run_btn = 1'b0;
      repeat (S + 3) begin
         check_idle("rst_then_run");
         step();
      end

      for (int it = 0; it < 25; it++) begin
         int clr_at;
         if (!m_ready || $urandom_range(0, 2) == 0) begin
            load_nib(4'($urandom));
            while (!m_ready) load_nib(4'($urandom));
         end
         clr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, S + 3)) : 0;
         do_run(clr_at == 0 && $urandom_range(0, 1) == 1, clr_at, 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Replaces the hand-driven strobe logic in front of the Control/Reg/ALU datapath.
- Assembles a 16-bit instruction from four switch nibbles entered by button presses.
- On a run request, issues the ALU execute, overflow-check and register-store strobes in a fixed, timed order.
- Suppresses the register write when the ALU reports overflow. Runs on the 100 MHz system clock.

Parameters:
- GAP_CYCLES, 4, settle cycles after execute_st and after overflow_st before the next step (legal range 1..15)
- NIB_W, 4, switch nibble width
- INSTR_W, 16, instruction width (= 4*NIB_W)

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous reset, active-low
- sw  in  NIB_W  nibble value to load
- load_btn  in  1  debounced level; rising edge loads sw into the current nibble
- run_btn  in  1  debounced level; rising edge starts execution
- clr_btn  in  1  debounced level; rising edge performs a synchronous clear
- overflow  in  1  ALU overflow flag
- instruction  out  INSTR_W  assembled instruction: [15:12] opcode, [11:0] operands
- execute_st  out  1  one-cycle ALU execute strobe
- overflow_st  out  1  one-cycle overflow-check strobe
- reg_store  out  1  one-cycle register write-back strobe
- nib_idx  out  2  index of the next nibble to load (drives LEDs)
- busy  out  1  execution in progress
- done  out  1  last execution finished
- ovf_flag  out  1  last execution overflowed; its store was skipped

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; instruction=0, nib_idx=0; all strobes, busy, done and ovf_flag are 0; edge-detector history is cleared to 0.
- Edge detection: edge = btn & ~btn_q, where btn_q is registered each clk. The FSM acts in the cycle the edge is high.
- All outputs are registered; each strobe is high for exactly one clk.
- States: IDLE, ENTRY, READY, EXEC, WAIT1, OVFCHK, WAIT2, STORE, DONE.
- Nibble load: writes sw into instruction[INSTR_W-1-NIB_W*nib_idx -: NIB_W], then nib_idx increments.
- IDLE/ENTRY + load edge: perform a nibble load, state ENTRY. When nib_idx wraps 3->0, state READY.
- READY/DONE + load edge: start a new instruction. Write nibble 0, nib_idx=1, state ENTRY, clear done and ovf_flag. Unwritten nibbles keep their old values.
- READY/DONE + run edge: go to EXEC and clear done and ovf_flag. A run edge from DONE re-executes the held instruction.
- run edge in IDLE/ENTRY: ignored.
- EXEC: execute_st=1 for one cycle, then WAIT1.
- WAIT1: lasts exactly GAP_CYCLES cycles (counter loaded with GAP_CYCLES-1, counts down to 0), then OVFCHK.
- OVFCHK: overflow_st=1 for one cycle, then WAIT2.
- WAIT2: lasts GAP_CYCLES cycles. overflow is sampled in the final WAIT2 cycle:
  - overflow=1: set ovf_flag=1, go to DONE; reg_store never pulses.
  - overflow=0: go to STORE.
- STORE: reg_store=1 for one cycle, then DONE.
- DONE: done=1 (level), held until the next load or run edge.
- busy=1 in EXEC, WAIT1, OVFCHK, WAIT2 and STORE.
- instruction and nib_idx are frozen while busy. load and run edges are ignored while busy.
- Timing with GAP_CYCLES=4, run edge in cycle 0:
  - execute_st in cycle 1
  - overflow_st in cycle 6
  - overflow sampled in cycle 10
  - reg_store in cycle 11
  - done=1 from cycle 12
  - Overflow case: done=1 and ovf_flag=1 from cycle 11.
- clr edge: highest priority in every state, including mid-execution.
  - Next cycle: state IDLE, instruction=0, nib_idx=0, all flags and strobes 0.
  - A strobe scheduled for that cycle is not issued.
- Simultaneous edges: clr > run > load. A load edge coinciding with a run edge in READY is dropped.
- Asynchronous reset mid-execution: strobes drop immediately; no partial store is issued after release.

Decomposition:
- Package seq_pkg holds:
  - state enum encoding
  - field constants OPC_MSB=15, OPC_LSB=12
  - nibble-slot mapping function
  - GAP counter width
- Sub-module btn_edge (one flop plus AND-NOT, async active-low reset) is instantiated three times, for load, run and clr.
- The FSM, nibble register and gap counter stay in the top module.

Test Plan:
- Load sw=1,2,3,4 with four load edges -> instruction=16'h1234, nib_idx sequence 1,2,3,0, state READY, busy=0.
- Run edge at cycle 0 with overflow=0, GAP_CYCLES=4 -> execute_st@1, overflow_st@6, reg_store@11, done=1 from 12, ovf_flag=0; each strobe exactly one cycle.
- Same as previous but overflow=1 from cycle 7 -> no reg_store pulse, ovf_flag=1 and done=1 from 11.
- Load and run edges during cycles 2..9 of an execution -> instruction stays 16'h1234, no extra strobes, same timing as the no-overflow run.
- clr edge at cycle 3 of an execution -> overflow_st and reg_store never pulse, instruction=0, nib_idx=0, busy=0 next cycle.
- rst low at cycle 5 of an execution, released 3 cycles later -> all outputs 0 immediately; a run edge after release is ignored (state IDLE).
